jtframe_data_io: RTL and testbench



---
 rtl/jtframe_data_io_pkg.sv | 15 +
 rtl/jtframe_toggle_sync.sv | 21 ++
 rtl/jtframe_data_io.sv | 140 ++++++++++++++
 tb/tb_jtframe_data_io.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_data_io_pkg.sv
// Shared constants for the SPI ROM download receiver.
// Holds the host file-transfer command codes and default port widths.
// No logic; imported by the top and its synchronizer.
package jtframe_data_io_pkg;

  // Default widths of the byte address and the file index
  localparam int DEF_AW   = 23;
  localparam int DEF_IDXW = 5;

  // File-transfer command codes sent as the first byte after ss falls
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h53;
  localparam logic [7:0] UIO_FILE_TX     = 8'h54;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h55;

endpackage

// File: rtl/jtframe_toggle_sync.sv
// Toggle-to-pulse synchronizer: turns each edge of a foreign-domain toggle into one pxl_clk pulse.
// Latency: pulse is high 2-3 pxl_clk edges after the toggle flips (combinational from stages 2/3).
// Backpressure: none; toggles must be at least 3 pxl_clk cycles apart or edges are merged.
module jtframe_toggle_sync (
  input  logic pxl_clk,
  input  logic rst_base,
  input  logic tgl,
  output logic pulse
);

  logic [2:0] sync;

  // Three-stage shift: first two stages resolve metastability, third holds the previous value
  always_ff @(posedge pxl_clk or posedge rst_base) begin
    if (rst_base) sync <= 3'b000;
    else          sync <= {sync[1:0], tgl};
  end

  assign pulse = sync[2] ^ sync[1];

endmodule

// File: rtl/jtframe_data_io.sv
// SPI-slave ROM download receiver: decodes host file-transfer commands and emits byte writes in pxl_clk.
// Latency: ioctl_wr strobes 3-4 pxl_clk cycles after the 8th sck rise of each data byte.
// Backpressure: none; the host must space bytes by at least 4 pxl_clk cycles (no FIFO).
module jtframe_data_io
  import jtframe_data_io_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int IDXW = DEF_IDXW
) (
  input  logic            pxl_clk,
  input  logic            rst_base,
  input  logic            sck,
  input  logic            ss,
  input  logic            sdi,
  output logic            downloading_sdram,
  output logic [IDXW-1:0] index,
  output logic [AW-1:0]   ioctl_addr,
  output logic [7:0]      ioctl_data,
  output logic            ioctl_wr
);

  // ---------------- SPI (sck) domain ----------------
  // Framing state is cleared whenever the host deselects us, so a partial
  // byte or a new ss cycle always restarts at a command byte.
  logic            spi_clr;
  logic [2:0]      bit_cnt;
  logic            cmd_rcvd;
  logic [6:0]      sbuf;
  logic [7:0]      cmd;
  logic [7:0]      byte_in;
  logic            byte_done;
  logic            tx_flag;
  logic            byte_tgl;
  logic [7:0]      data_spi;
  logic [IDXW-1:0] index_spi;

  assign spi_clr   = rst_base | ss;
  assign byte_in   = {sbuf, sdi};
  assign byte_done = (bit_cnt == 3'd7);

  // Bit counter and command-received flag, cleared by deselect or reset
  always_ff @(posedge sck or posedge spi_clr) begin
    if (spi_clr) begin
      bit_cnt  <= 3'd0;
      cmd_rcvd <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (byte_done) cmd_rcvd <= 1'b1;
    end
  end

  // Shift register and command decode; results survive ss so pxl_clk can pick them up
  always_ff @(posedge sck or posedge rst_base) begin
    if (rst_base) begin
      sbuf      <= 7'd0;
      cmd       <= 8'h00;
      tx_flag   <= 1'b0;
      byte_tgl  <= 1'b0;
      data_spi  <= 8'h00;
      index_spi <= '0;
    end else begin
      sbuf <= byte_in[6:0];
      if (byte_done) begin
        if (!cmd_rcvd) begin
          cmd <= byte_in;
        end else begin
          case (cmd)
            UIO_FILE_INDEX:  index_spi <= byte_in[IDXW-1:0];
            UIO_FILE_TX:     tx_flag   <= (byte_in != 8'h00);
            UIO_FILE_TX_DAT: begin
              if (tx_flag) begin
                data_spi <= byte_in;
                byte_tgl <= ~byte_tgl;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- pxl_clk domain ----------------
  logic            byte_pulse;
  logic            dl_s0;
  logic            dl_q;
  logic            dl_rise;
  logic [IDXW-1:0] idx_s0;
  logic [AW-1:0]   addr_cnt;

  jtframe_toggle_sync u_byte_sync (
    .pxl_clk  (pxl_clk),
    .rst_base (rst_base),
    .tgl      (byte_tgl),
    .pulse    (byte_pulse)
  );

  assign dl_rise = downloading_sdram & ~dl_q;

  // Two-flop synchronizers for the transfer flag and the file index
  always_ff @(posedge pxl_clk or posedge rst_base) begin
    if (rst_base) begin
      dl_s0             <= 1'b0;
      downloading_sdram <= 1'b0;
      dl_q              <= 1'b0;
      idx_s0            <= '0;
      index             <= '0;
    end else begin
      dl_s0             <= tx_flag;
      downloading_sdram <= dl_s0;
      dl_q              <= downloading_sdram;
      idx_s0            <= index_spi;
      index             <= idx_s0;
    end
  end

  // Write strobe: address and data are captured with the strobe and held until the next one.
  // data_spi has been stable for at least two cycles when the pulse arrives.
  always_ff @(posedge pxl_clk or posedge rst_base) begin
    if (rst_base) begin
      ioctl_wr   <= 1'b0;
      ioctl_data <= 8'h00;
      ioctl_addr <= '0;
    end else begin
      ioctl_wr <= byte_pulse;
      if (byte_pulse) begin
        ioctl_data <= data_spi;
        ioctl_addr <= addr_cnt;
      end
    end
  end

  // Next-address counter: cleared when a transfer opens, advances the cycle after each strobe
  always_ff @(posedge pxl_clk or posedge rst_base) begin
    if (rst_base)      addr_cnt <= '0;
    else if (dl_rise)  addr_cnt <= '0;
    else if (ioctl_wr) addr_cnt <= addr_cnt + 1'b1;
  end

endmodule

// File: tb/tb_jtframe_data_io.sv
// Directed bench for the SPI ROM download receiver.
// Bit-bangs host command frames and records every ioctl_wr strobe.
// Expected addresses, data and flags are hand-computed constants.
module tb_jtframe_data_io;

  logic        pxl_clk = 1'b0;
  logic        rst_base = 1'b1;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        sdi = 1'b0;
  logic        downloading_sdram;
  logic [4:0]  index;
  logic [22:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;

  int n_vec = 0;
  int n_err = 0;

  jtframe_data_io dut (
    .pxl_clk           (pxl_clk),
    .rst_base          (rst_base),
    .sck               (sck),
    .ss                (ss),
    .sdi               (sdi),
    .downloading_sdram (downloading_sdram),
    .index             (index),
    .ioctl_addr        (ioctl_addr),
    .ioctl_data        (ioctl_data),
    .ioctl_wr          (ioctl_wr)
  );

  always #5 pxl_clk = ~pxl_clk;

  // Cycle counter and strobe recorder
  int          cyc = 0;
  int          nwr = 0;
  int          wr_cyc = 0;
  int          last_edge_cyc = 0;
  int          dbl = 0;
  logic        prev_wr = 1'b0;
  logic [22:0] wa [16];
  logic [7:0]  wd [16];

  always @(posedge pxl_clk) cyc <= cyc + 1;

  always @(negedge pxl_clk) begin
    if (ioctl_wr) begin
      if (nwr < 16) begin
        wa[nwr] = ioctl_addr;
        wd[nwr] = ioctl_data;
      end
      nwr++;
      wr_cyc = cyc;
      if (prev_wr) dbl++;
    end
    prev_wr = ioctl_wr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send the top nbits of b, MSB first; sck edges fall on pxl_clk negedges
  task automatic spi_bits(input logic [7:0] b, input int nbits);
    @(negedge pxl_clk);
    for (int i = 7; i >= 8 - nbits; i--) begin
      sdi = b[i];
      #20 sck = 1'b1;
      last_edge_cyc = cyc;
      #20 sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic ss_lo();
    @(negedge pxl_clk);
    ss = 1'b0;
  endtask

  task automatic ss_hi();
    #20 ss = 1'b1;
  endtask

  task automatic frame2(input logic [7:0] c, input logic [7:0] p);
    ss_lo();
    spi_byte(c);
    spi_byte(p);
    ss_hi();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge pxl_clk);
    #1;
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    chk("rst_dl", downloading_sdram, 0);
    chk("rst_index", index, 0);
    chk("rst_addr", ioctl_addr, 0);
    chk("rst_data", ioctl_data, 0);
    chk("rst_wr", ioctl_wr, 0);
    rst_base = 1'b0;
    // sck activity with ss idle high must not produce anything
    spi_byte(8'h55);
    spi_byte(8'hA5);
    wait_cyc(8);
    chk("idle_nowr", nwr, 0);

    // File index
    frame2(8'h53, 8'h04);
    wait_cyc(3);
    chk("index", index, 4);

    // Open transfer and send three bytes
    frame2(8'h54, 8'h01);
    wait_cyc(4);
    chk("dl_open", downloading_sdram, 1);
    ss_lo();
    spi_byte(8'h55);
    spi_byte(8'hA5);
    spi_byte(8'h5A);
    spi_byte(8'hFF);
    ss_hi();
    wait_cyc(8);
    chk("nwr3", nwr, 3);
    chk("wr0_addr", wa[0], 0);
    chk("wr0_data", wd[0], 8'hA5);
    chk("wr1_addr", wa[1], 1);
    chk("wr1_data", wd[1], 8'h5A);
    chk("wr2_addr", wa[2], 2);
    chk("wr2_data", wd[2], 8'hFF);
    chk("hold_addr", ioctl_addr, 2);
    chk("hold_data", ioctl_data, 8'hFF);

    // Close transfer; further data is ignored
    frame2(8'h54, 8'h00);
    wait_cyc(4);
    chk("dl_close", downloading_sdram, 0);
    ss_lo();
    spi_byte(8'h55);
    spi_byte(8'h77);
    spi_byte(8'h88);
    ss_hi();
    wait_cyc(10);
    chk("closed_nowr", nwr, 3);

    // Unknown command payload is ignored
    frame2(8'h12, 8'h99);
    wait_cyc(6);
    chk("unk_nowr", nwr, 3);
    chk("unk_index", index, 4);

    // Restart: address starts from 0 again
    frame2(8'h54, 8'h01);
    wait_cyc(4);
    chk("dl_reopen", downloading_sdram, 1);
    frame2(8'h55, 8'h11);
    wait_cyc(6);
    chk("nwr4", nwr, 4);
    chk("wr3_addr", wa[3], 0);
    chk("wr3_data", wd[3], 8'h11);
    chk("latency", ((wr_cyc - last_edge_cyc) >= 3) && ((wr_cyc - last_edge_cyc) <= 4), 1);

    // Abort after 5 bits: no strobe, and framing restarts cleanly
    ss_lo();
    spi_byte(8'h55);
    spi_bits(8'hC3, 5);
    ss_hi();
    wait_cyc(10);
    chk("partial_nowr", nwr, 4);
    frame2(8'h55, 8'h22);
    wait_cyc(6);
    chk("nwr5", nwr, 5);
    chk("wr4_addr", wa[4], 1);
    chk("wr4_data", wd[4], 8'h22);

    // Reset mid-transfer
    @(negedge pxl_clk);
    rst_base = 1'b1;
    #1;
    chk("mid_rst_dl", downloading_sdram, 0);
    chk("mid_rst_addr", ioctl_addr, 0);
    chk("mid_rst_data", ioctl_data, 0);
    wait_cyc(2);
    rst_base = 1'b0;
    frame2(8'h55, 8'h33);
    wait_cyc(8);
    chk("post_rst_dl", downloading_sdram, 0);
    chk("post_rst_nowr", nwr, 5);

    chk("single_cycle", dbl, 0);
    chk("final_wr", ioctl_wr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
